irq_sequencer_ctrl: RTL and testbench

//  Interrupt controller that sequences the program sequencer: latches irq edges, arbitrates by priority,

---
 rtl/irq_pkg.sv | 23 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_sequencer_ctrl.sv | 166 ++++++++++++++++
 tb/tb_irq_sequencer_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt sequencer controller.
package irq_pkg;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned MAX_IRQ = 8;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic [1:0] {
      StIdle,
      StDispatch,
      StInIsr,
      StReturn
   } irq_state_t;

   // Vector for source id: high nibble is base + id, low nibble zero.
   function automatic logic [ADDR_W-1:0] vec_addr(input logic [3:0]       base,
                                                  input logic [IDX_W-1:0] id);
      logic [3:0] hi;
      hi = base + {1'b0, id};
      return {hi, 4'h0};
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: index 0 is the highest priority.
import irq_pkg::*;

module irq_prio_enc #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]     req_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            valid_o = 1'b1;
            idx_o   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_sequencer_ctrl.sv
// Interrupt controller driving the program sequencer: edge latch, priority dispatch, RETI return.
// Build option IRQ_NESTING_EN: two-deep return stack with strictly-higher-priority preemption.
import irq_pkg::*;

module irq_sequencer_ctrl #(
   parameter int unsigned N_IRQ    = 4,
   parameter logic [3:0]  VEC_BASE = 4'h8
) (
   input  logic              clk,
   input  logic              sync_reset,
   input  logic [N_IRQ-1:0]  irq_req,
   input  logic              ie_wr,
   input  logic [N_IRQ-1:0]  ie_data,
   input  logic [ADDR_W-1:0] pc,
   input  logic              cpu_jmp,
   input  logic              instr_reti,
   output logic              irq_jmp,
   output logic [ADDR_W-1:0] irq_addr,
   output logic [N_IRQ-1:0]  irq_ack,
   output logic [N_IRQ-1:0]  irq_pending,
   output logic              in_isr
);

`ifdef IRQ_NESTING_EN
   localparam int unsigned DEPTH = 2;
`else
   localparam int unsigned DEPTH = 1;
`endif

   if (N_IRQ < 1 || N_IRQ > MAX_IRQ || int'(VEC_BASE) + int'(N_IRQ) > 16) begin : g_bad_cfg
      $error("irq_sequencer_ctrl: invalid N_IRQ/VEC_BASE combination");
   end

   irq_state_t        state_q, state_d;
   logic [N_IRQ-1:0]  irq_q, pending_q, pending_d, mask_q, eligible, ack_q, ack_d;
   logic              irq_jmp_q, irq_jmp_d, in_isr_q;
   logic [ADDR_W-1:0] addr_q, addr_d, top_ret;
   logic [ADDR_W-1:0] ret_q [DEPTH];
   logic [1:0]        sp_q, sp_d;
   logic              enc_valid, preempt;
   logic [IDX_W-1:0]  enc_idx;

   assign eligible  = pending_q & mask_q;
   // A new edge in the same cycle as its ack must survive.
   assign pending_d = (pending_q & ~ack_q) | (irq_req & ~irq_q);

   irq_prio_enc #(
      .N (N_IRQ)
   ) u_prio_enc (
      .req_i   (eligible),
      .valid_o (enc_valid),
      .idx_o   (enc_idx)
   );

   always_comb begin
      top_ret = '0;
      for (int j = 0; j < int'(DEPTH); j++) begin
         if (sp_q == 2'(j + 1)) top_ret = ret_q[j];
      end
   end

`ifdef IRQ_NESTING_EN
   logic [IDX_W-1:0] win_q, top_prio;
   logic [IDX_W-1:0] prio_q [DEPTH];

   always_comb begin
      top_prio = '0;
      for (int j = 0; j < int'(DEPTH); j++) begin
         if (sp_q == 2'(j + 1)) top_prio = prio_q[j];
      end
   end

   assign preempt = enc_valid && (enc_idx < top_prio) && (sp_q < 2'(DEPTH));

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         win_q <= '0;
         for (int j = 0; j < int'(DEPTH); j++) prio_q[j] <= '0;
      end else begin
         if (state_d == StDispatch) win_q <= enc_idx;
         if (state_q == StDispatch) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
               if (sp_q == 2'(j)) prio_q[j] <= win_q;
            end
         end
      end
   end
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      sp_d      = sp_q;
      irq_jmp_d = 1'b0;
      addr_d    = '0;
      ack_d     = '0;
      unique case (state_q)
         StIdle: begin
            if (enc_valid && !cpu_jmp) state_d = StDispatch;
         end
         StDispatch: begin
            state_d = StInIsr;
            sp_d    = sp_q + 2'd1;
         end
         StInIsr: begin
            if (instr_reti) begin
               state_d = StReturn;
               sp_d    = sp_q - 2'd1;
            end else if (preempt && !cpu_jmp) begin
               state_d = StDispatch;
            end
         end
         StReturn: begin
            state_d = (sp_q != 2'd0) ? StInIsr : StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Outputs are registered, so they are decoded from the state being entered.
      if (state_d == StDispatch) begin
         irq_jmp_d = 1'b1;
         addr_d    = vec_addr(VEC_BASE, enc_idx);
         for (int i = 0; i < int'(N_IRQ); i++) ack_d[i] = (enc_idx == IDX_W'(i));
      end else if (state_d == StReturn) begin
         irq_jmp_d = 1'b1;
         addr_d    = top_ret;
      end
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q   <= StIdle;
         irq_q     <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         ack_q     <= '0;
         irq_jmp_q <= 1'b0;
         addr_q    <= '0;
         in_isr_q  <= 1'b0;
         sp_q      <= '0;
         for (int j = 0; j < int'(DEPTH); j++) ret_q[j] <= '0;
      end else begin
         state_q   <= state_d;
         irq_q     <= irq_req;
         pending_q <= pending_d;
         if (ie_wr) mask_q <= ie_data;
         ack_q     <= ack_d;
         irq_jmp_q <= irq_jmp_d;
         addr_q    <= addr_d;
         in_isr_q  <= (state_d != StIdle);
         sp_q      <= sp_d;
         if (state_q == StDispatch) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
               if (sp_q == 2'(j)) ret_q[j] <= pc + 8'h01;
            end
         end
      end
   end

   assign irq_jmp     = irq_jmp_q;
   assign irq_addr    = addr_q;
   assign irq_ack     = ack_q;
   assign irq_pending = pending_q;
   assign in_isr      = in_isr_q;

endmodule

// File: tb/tb_irq_sequencer_ctrl.sv
// Directed self-checking bench for irq_sequencer_ctrl (N_IRQ=4, VEC_BASE=8).
module tb_irq_sequencer_ctrl;

   logic       clk;
   logic       sync_reset;
   logic [3:0] irq_req;
   logic       ie_wr;
   logic [3:0] ie_data;
   logic [7:0] pc;
   logic       cpu_jmp;
   logic       instr_reti;
   logic       irq_jmp;
   logic [7:0] irq_addr;
   logic [3:0] irq_ack;
   logic [3:0] irq_pending;
   logic       in_isr;

   int errors = 0;
   int checks = 0;

   irq_sequencer_ctrl #(
      .N_IRQ    (4),
      .VEC_BASE (4'h8)
   ) dut (
      .clk         (clk),
      .sync_reset  (sync_reset),
      .irq_req     (irq_req),
      .ie_wr       (ie_wr),
      .ie_data     (ie_data),
      .pc          (pc),
      .cpu_jmp     (cpu_jmp),
      .instr_reti  (instr_reti),
      .irq_jmp     (irq_jmp),
      .irq_addr    (irq_addr),
      .irq_ack     (irq_ack),
      .irq_pending (irq_pending),
      .in_isr      (in_isr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks the full output vector {jmp, addr, ack, in_isr}.
   task automatic chk_out(input string tag, input logic j, input logic [7:0] a,
                          input logic [3:0] k, input logic isr);
      chk({tag, ".jmp"}, 32'(irq_jmp), 32'(j));
      chk({tag, ".addr"}, 32'(irq_addr), 32'(a));
      chk({tag, ".ack"}, 32'(irq_ack), 32'(k));
      chk({tag, ".isr"}, 32'(in_isr), 32'(isr));
   endtask

   initial begin
      sync_reset = 1'b1;
      irq_req    = 4'b0000;
      ie_wr      = 1'b0;
      ie_data    = 4'b0000;
      pc         = 8'h00;
      cpu_jmp    = 1'b0;
      instr_reti = 1'b0;
      step();
      step();
      sync_reset = 1'b0;
      chk_out("reset", 1'b0, 8'h00, 4'b0000, 1'b0);
      chk("reset.pend", 32'(irq_pending), 32'h0);

      // RETI while idle is ignored
      instr_reti = 1'b1;
      step();
      instr_reti = 1'b0;
      chk_out("reti_idle", 1'b0, 8'h00, 4'b0000, 1'b0);

      // Test 1: mask 0011, src1 and masked src2 rise
      ie_wr   = 1'b1;
      ie_data = 4'b0011;
      step();
      ie_wr   = 1'b0;
      pc      = 8'h23;
      irq_req = 4'b0110;
      step();
      chk("t1.pend", 32'(irq_pending), 32'h6);
      chk("t1.nojmp", 32'(irq_jmp), 32'h0);
      step();
      chk_out("t1.disp", 1'b1, 8'h90, 4'b0010, 1'b1);
      step();
      chk_out("t1.isr", 1'b0, 8'h00, 4'b0000, 1'b1);
      chk("t1.pend2", 32'(irq_pending), 32'h4);
      // Test 2: RETI
      instr_reti = 1'b1;
      step();
      instr_reti = 1'b0;
      chk_out("t2.ret", 1'b1, 8'h24, 4'b0000, 1'b1);
      step();
      chk_out("t2.idle", 1'b0, 8'h00, 4'b0000, 1'b0);
      step();
      chk("t2.masked", 32'(irq_jmp), 32'h0);

      // Test 3: src0 rises, src2 already pending, mask F
      ie_wr   = 1'b1;
      ie_data = 4'b1111;
      irq_req = 4'b0111;
      pc      = 8'h40;
      step();
      ie_wr = 1'b0;
      chk("t3.pend", 32'(irq_pending), 32'h5);
      step();
      chk_out("t3.disp0", 1'b1, 8'h80, 4'b0001, 1'b1);
      step();
      chk("t3.pend2", 32'(irq_pending), 32'h4);
      instr_reti = 1'b1;
      step();
      instr_reti = 1'b0;
      chk_out("t3.ret0", 1'b1, 8'h41, 4'b0000, 1'b1);
      step();
      chk("t3.idle", 32'(in_isr), 32'h0);
      step();
      chk_out("t3.disp2", 1'b1, 8'hA0, 4'b0100, 1'b1);
      step();
      chk("t3.pend3", 32'(irq_pending), 32'h0);
      instr_reti = 1'b1;
      step();
      instr_reti = 1'b0;
      chk_out("t3.ret2", 1'b1, 8'h41, 4'b0000, 1'b1);
      step();

      // Test 4: src3 rises while cpu_jmp held 3 cycles
      cpu_jmp = 1'b1;
      irq_req = 4'b1000;
      step();
      chk("t4.pend", 32'(irq_pending), 32'h8);
      step();
      chk("t4.hold1", 32'(irq_jmp), 32'h0);
      step();
      chk("t4.hold2", 32'(irq_jmp), 32'h0);
      cpu_jmp = 1'b0;
      step();
      chk_out("t4.disp", 1'b1, 8'hB0, 4'b1000, 1'b1);
      // Test 5: pc wrap on return address
      pc = 8'hFF;
      step();
      chk("t5.nojmp", 32'(irq_jmp), 32'h0);
      instr_reti = 1'b1;
      step();
      instr_reti = 1'b0;
      chk_out("t5.wrap", 1'b1, 8'h00, 4'b0000, 1'b1);
      step();
      chk("t5.idle", 32'(in_isr), 32'h0);

`ifdef IRQ_NESTING_EN
      // Test 6: src2 ISR preempted by src0, LIFO returns
      irq_req = 4'b1100;
      pc      = 8'h30;
      step();
      step();
      chk_out("t6.disp2", 1'b1, 8'hA0, 4'b0100, 1'b1);
      step();
      irq_req = 4'b1101;
      pc      = 8'h50;
      step();
      chk("t6.pend0", 32'(irq_pending), 32'h1);
      step();
      chk_out("t6.disp0", 1'b1, 8'h80, 4'b0001, 1'b1);
      step();
      instr_reti = 1'b1;
      step();
      instr_reti = 1'b0;
      chk_out("t6.ret0", 1'b1, 8'h51, 4'b0000, 1'b1);
      step();
      chk("t6.still", 32'(in_isr), 32'h1);
      instr_reti = 1'b1;
      step();
      instr_reti = 1'b0;
      chk_out("t6.ret2", 1'b1, 8'h31, 4'b0000, 1'b1);
      step();
      chk("t6.idle", 32'(in_isr), 32'h0);
`endif

      // Test 5b: reset while inside an ISR with another request pending
      irq_req = 4'b0000;
      step();
      irq_req = 4'b0001;
      step();
      step();
      chk("t5b.disp", 32'(irq_addr), 32'h80);
      step();
      irq_req = 4'b0101;
      step();
      chk("t5b.pend", 32'(irq_pending), 32'h4);
      chk("t5b.isr", 32'(in_isr), 32'h1);
      sync_reset = 1'b1;
      irq_req    = 4'b0000;
      step();
      chk_out("t5b.rst", 1'b0, 8'h00, 4'b0000, 1'b0);
      chk("t5b.rstpend", 32'(irq_pending), 32'h0);
      sync_reset = 1'b0;
      step();
      chk_out("t5b.after", 1'b0, 8'h00, 4'b0000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
